seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detection controller. Host loads a pattern, length, match target and overlap mode, then arms a run. Block samples a qualified serial bit stream, pulses detect on each match and counts matches. Halts when the target count is reached. Sits between the host/config side and the serial input, as the run-controlled successor of the fixed 1001 detector.

Parameters:
PAT_W, 4, maximum pattern length in bits (>=2)
CNT_W, 8, width of the match counter and target
LEN_W, $clog2(PAT_W+1), width of cfg_len (derived; do not override)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  config write request
cfg_ready  output  1  config accepted this cycle when high with cfg_valid
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first-received bit, bit [0] the last
cfg_len  input  LEN_W  pattern length in bits
cfg_target  input  CNT_W  matches before halt; 0 = run forever
cfg_overlap  input  1  1 = overlapping matches allowed
start  input  1  arm run (IDLE) / acknowledge halt (HALT)
abort  input  1  stop run immediately
seq_valid  input  1  seq qualifier
seq  input  1  serial data bit
detect  output  1  one-cycle match pulse
match_cnt  output  CNT_W  matches in current/last run
busy  output  1  high in RUN
done  output  1  high in HALT

Behaviour:
- One clock domain. rst_n is asynchronous and active-low; every flop clears on reset.
- Reset values:
  - state=IDLE, detect=0, match_cnt=0, busy=0, done=0, cfg_ready=1.
  - Config registers: pattern={PAT_W{0}} with low 4 bits 1001 (when PAT_W>=4), len=min(4,PAT_W), target=0, overlap=1.
  - Reset mid-run aborts immediately. No pulse is generated from a partially received pattern.
- FSM has three states: IDLE, RUN, HALT.
  - cfg_ready = (state==IDLE), combinational from state.
  - IDLE:
    - cfg_valid latches all cfg_* fields. cfg_len of 0 or >PAT_W is latched as PAT_W.
    - start (without cfg_valid) goes to RUN next cycle, and on that same edge clears history, fill count and match_cnt.
    - cfg_valid and start in the same cycle: config latched, start ignored, stay IDLE.
  - RUN (busy=1):
    - abort has top priority: go to IDLE next cycle. That cycle's bit is not shifted, no detect, match_cnt retained.
    - Otherwise, on seq_valid=1:
      - hist <= {hist[PAT_W-2:0], seq}.
      - fill <= min(fill+1, len).
      - A match occurs when the updated fill >= len and the updated hist[len-1:0] == pattern[len-1:0].
      - seq is ignored while seq_valid=0; history, fill and counter hold.
  - HALT (done=1): seq ignored. start or abort returns to IDLE next cycle. match_cnt holds until the next run starts.
- On a match:
  - detect=1 for exactly one cycle, registered. It is high in the cycle after the edge that sampled the completing bit.
  - match_cnt increments on the same edge that sets detect, saturating at all-ones.
  - overlap=0: fill cleared to 0, so the next match needs len fresh bits.
  - overlap=1: fill kept, so a suffix of this match may start the next one.
  - If target!=0 and the incremented count == target, go to HALT. detect still pulses for that final match.
- Transitions take effect on the clock edge; busy and done are registered decodes of state.
- Config registers change only through the IDLE cfg handshake; they are never modified during RUN/HALT.

Test Plan:
1. Reset defaults (1001, len 4, overlap 1, target 0); start; valid bits 1,0,0,1,0,0,1 -> detect pulses after bit 4 and after bit 7; match_cnt=2; busy stays 1.
2. Load cfg_overlap=0, otherwise default; start; same 7-bit stream -> detect only after bit 4; match_cnt=1 (bits 5-7 give fill 3 < 4).
3. Load pattern 3'b110, len 3, target 2; start; bits 1,1,0,1,1,0,1,1,0 -> detect after bits 3 and 6; HALT after the second match with done=1, busy=0, match_cnt=2; bits 7-9 ignored.
4. Default config; stream 1,0,0,1 with seq_valid low for 1-3 cycles between bits while seq toggles -> exactly one detect, after the last valid bit.
5. Abort asserted in the same cycle as the completing 1 of 1001 -> no detect, IDLE next cycle, match_cnt unchanged. Separately, cfg_valid+start in the same IDLE cycle -> config latched, busy stays 0. cfg_len=0 -> latched as PAT_W.
6. CNT_W=2, target 0, overlap 1: pattern 11 len 2, stream of six 1s -> five detects; match_cnt saturates at 3. Assert rst_n low mid-run -> detect/busy/done/match_cnt clear at once, cfg_ready=1, and config reverts to default 1001 on next run.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Programmable serial pattern-detection controller. The host loads a
//   pattern, its length, a match target and an overlap mode while IDLE,
//   then arms a run with start. During RUN each qualified serial bit is
//   shifted into a history register. A match is reported with a one-cycle
//   detect pulse and counted in match_cnt. The controller halts when the
//   target count is reached. A target of 0 means run forever.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   cfg_valid       : config write request, accepted when cfg_ready is high
//   cfg_ready       : high in IDLE
//   cfg_pattern     : pattern; bit [len-1] is received first, bit [0] last
//   cfg_len         : pattern length; 0 or >PAT_W is taken as PAT_W
//   cfg_target      : matches before halt (0 = never halt)
//   cfg_overlap     : 1 = a match suffix may begin the next match
//   start           : arm a run (IDLE) / acknowledge halt (HALT)
//   abort           : leave RUN/HALT immediately
//   seq_valid, seq  : qualified serial input bit
//   detect          : registered one-cycle match pulse
//   match_cnt       : saturating match count of the current/last run
//   busy / done     : registered RUN / HALT indicators
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             abort,
    input  logic             seq_valid,
    input  logic             seq,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [PAT_W-1:0] PAT_RST = (PAT_W >= 4) ? PAT_W'(4'b1001) : '0;
    localparam logic [LEN_W-1:0] LEN_RST = (PAT_W >= 4) ? LEN_W'(4) : LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t state, state_nxt;

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] tgt_q;
    logic             ovl_q;

    // Only the newest PAT_W-1 bits are stored; the incoming bit completes
    // the PAT_W-bit window that is compared against the pattern.
    logic [PAT_W-2:0] hist_q;
    logic [LEN_W-1:0] fill_q;

    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] ones;
    logic [LEN_W-1:0] fill_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             shift_en;
    logic             pat_hit;
    logic             match;
    logic             hit_target;
    logic             run_start;
    logic             busy_nxt;
    logic             done_nxt;

    // ------------------------------------------------------------------
    // Match datapath
    // ------------------------------------------------------------------
    always_comb begin
        ones       = '1;
        hist_nxt   = {hist_q, seq};
        len_mask   = ~(ones << len_q);
        fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        shift_en   = (state == S_RUN) && !abort && seq_valid;
        pat_hit    = ((hist_nxt ^ pat_q) & len_mask) == '0;
        match      = shift_en && (fill_inc >= len_q) && pat_hit;
        cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
        hit_target = (tgt_q != '0) && (cnt_inc == tgt_q);
        run_start  = (state == S_IDLE) && start && !cfg_valid;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (run_start) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)                   state_nxt = S_IDLE;
                else if (match && hit_target) state_nxt = S_HALT;
            end
            S_HALT: if (start || abort) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (busy/done are decoded from the next state so that
    // their registered copies line up with the state register)
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready = (state == S_IDLE);
        busy_nxt  = (state_nxt == S_RUN);
        done_nxt  = (state_nxt == S_HALT);
    end

    // ------------------------------------------------------------------
    // Configuration registers: written only through the IDLE handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PAT_RST;
            len_q <= LEN_RST;
            tgt_q <= '0;
            ovl_q <= 1'b1;
        end else if ((state == S_IDLE) && cfg_valid) begin
            pat_q <= cfg_pattern;
            len_q <= ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
            tgt_q <= cfg_target;
            ovl_q <= cfg_overlap;
        end
    end

    // ------------------------------------------------------------------
    // Run datapath: history, fill level, detect pulse, match counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            detect    <= 1'b0;
            match_cnt <= '0;
        end else begin
            detect <= match;
            if (run_start) begin
                hist_q    <= '0;
                fill_q    <= '0;
                match_cnt <= '0;
            end else if (shift_en) begin
                hist_q <= hist_nxt[PAT_W-2:0];
                // Non-overlapping mode forces the next match to be built
                // entirely from fresh bits.
                fill_q <= (match && !ovl_q) ? '0 : fill_inc;
                if (match) match_cnt <= cnt_inc;
            end
        end
    end

endmodule
